// File: rtl/i2s_adc_receiver_if.sv
// i2s_adc_receiver_if
//   Groups the codec serial pins and the published stereo sample bus of the
//   I2S ADC receiver.
//   Signals:
//     AUD_BCLK     codec bit clock (asynchronous to the system clock)
//     AUD_ADCLRCK  codec word clock; 0 = left, 1 = right
//     AUD_ADCDAT   codec serial ADC data, MSB first
//     out_L/out_R  signed left/right sample of the latest complete pair
//     out_valid    one-cycle strobe, out_L/out_R just updated
//     frame_err    one-cycle strobe, word clock edge cut a word short
//   Modports:
//     slave   the receiver (consumes pins, drives the sample bus)
//     master  the codec/consumer side (drives pins, reads the sample bus)
interface i2s_adc_receiver_if #(
    parameter int OUT_WIDTH = 32
);
    logic                 AUD_BCLK;
    logic                 AUD_ADCLRCK;
    logic                 AUD_ADCDAT;
    logic [OUT_WIDTH-1:0] out_L;
    logic [OUT_WIDTH-1:0] out_R;
    logic                 out_valid;
    logic                 frame_err;

    modport slave (
        input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
        output out_L, out_R, out_valid, frame_err
    );

    modport master (
        output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
        input  out_L, out_R, out_valid, frame_err
    );
endinterface

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
//   Deserializes the codec I2S ADC stream into signed OUT_WIDTH-bit stereo
//   samples. Codec pins are synchronized into CLOCK_50; a left/right pair is
//   published together with a one-cycle out_valid strobe.
//   Parameters:
//     SAMPLE_BITS  bits captured per channel word (16..32), MSB first
//     OUT_WIDTH    published sample width, sign-extended from SAMPLE_BITS
//   Ports:
//     CLOCK_50  system clock
//     resetn    asynchronous active-low reset
//     bus       i2s_adc_receiver_if.slave: codec pins in, sample bus out
module i2s_adc_receiver #(
    parameter int SAMPLE_BITS = 24,
    parameter int OUT_WIDTH   = 32
) (
    input logic               CLOCK_50,
    input logic               resetn,
    i2s_adc_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SKIP, S_SHIFT, S_DONE, S_WAIT} state_t;

    state_t state, state_next;

    logic bclk_meta, bclk_sync, bclk_prev;
    logic lr_meta, lr_sync, lr_prev;
    logic dat_meta, dat_sync;
    logic bclk_rise, lr_edge;

    logic [CNT_W-1:0]       bit_cnt;
    logic [SAMPLE_BITS-1:0] shift_reg;
    logic [SAMPLE_BITS-1:0] pending_l;
    logic                   left_ok;
    logic                   word_right;

    logic [OUT_WIDTH-1:0] out_l_q, out_r_q;
    logic                 out_valid_q, frame_err_q;

    logic   clr_cnt, do_shift, word_done, store_left, publish, clear_left_ok, raise_err;
    state_t realign_state;

    function automatic logic [OUT_WIDTH-1:0] sign_extend(input logic [SAMPLE_BITS-1:0] w);
        return OUT_WIDTH'($signed(w));
    endfunction

    // Two flops per pin for metastability, a third on BCLK/LRCK for edge detect
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_prev <= 1'b0;
            lr_meta   <= 1'b0;
            lr_sync   <= 1'b0;
            lr_prev   <= 1'b0;
            dat_meta  <= 1'b0;
            dat_sync  <= 1'b0;
        end else begin
            bclk_meta <= bus.AUD_BCLK;
            bclk_sync <= bclk_meta;
            bclk_prev <= bclk_sync;
            lr_meta   <= bus.AUD_ADCLRCK;
            lr_sync   <= lr_meta;
            lr_prev   <= lr_sync;
            dat_meta  <= bus.AUD_ADCDAT;
            dat_sync  <= dat_meta;
        end
    end

    assign bclk_rise = bclk_sync & ~bclk_prev;
    assign lr_edge   = lr_sync ^ lr_prev;

    // A bit-clock rise coinciding with the word-clock edge serves as the
    // I2S delay bit, so the new word starts shifting immediately
    assign realign_state = bclk_rise ? S_SHIFT : S_SKIP;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word-clock edges always win: they realign the receiver to the new
    // channel from any state, and flag an error if a word was cut short
    always_comb begin
        state_next    = state;
        clr_cnt       = 1'b0;
        do_shift      = 1'b0;
        word_done     = 1'b0;
        store_left    = 1'b0;
        publish       = 1'b0;
        clear_left_ok = 1'b0;
        raise_err     = 1'b0;
        case (state)
            S_IDLE: begin
                if (lr_edge) begin
                    state_next = realign_state;
                    clr_cnt    = 1'b1;
                end
            end
            S_SKIP: begin
                if (lr_edge || bclk_rise) begin
                    state_next = lr_edge ? realign_state : S_SHIFT;
                    clr_cnt    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (lr_edge) begin
                    raise_err     = 1'b1;
                    clear_left_ok = 1'b1;
                    clr_cnt       = 1'b1;
                    state_next    = realign_state;
                end else if (bclk_rise) begin
                    do_shift = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        word_done  = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!word_right) begin
                    store_left = 1'b1;
                end else begin
                    publish       = left_ok;
                    clear_left_ok = 1'b1;
                end
                if (lr_edge) begin
                    state_next = realign_state;
                    clr_cnt    = 1'b1;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lr_edge) begin
                    state_next = realign_state;
                    clr_cnt    = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Shift register, left-word holding register and the published pair
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            pending_l   <= '0;
            left_ok     <= 1'b0;
            word_right  <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= publish;
            frame_err_q <= raise_err;
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (do_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (do_shift) begin
                shift_reg <= {shift_reg[SAMPLE_BITS-2:0], dat_sync};
            end
            if (word_done) begin
                word_right <= lr_sync;
            end
            if (store_left) begin
                pending_l <= shift_reg;
                left_ok   <= 1'b1;
            end else if (clear_left_ok) begin
                left_ok <= 1'b0;
            end
            if (publish) begin
                out_l_q <= sign_extend(pending_l);
                out_r_q <= sign_extend(shift_reg);
            end
        end
    end

    assign bus.out_L     = out_l_q;
    assign bus.out_R     = out_r_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb_i2s_adc_receiver
//   Drives an I2S ADC stream into two receivers (24-bit and 16-bit words)
//   sharing the same codec pins. Frames come from a vector table plus a few
//   hand-written sequences (truncated slot, reset mid-word); expected pairs
//   are queued when a frame is driven and popped when out_valid fires.
module tb_i2s_adc_receiver;
    typedef struct {
        logic [31:0] lw;
        logic [31:0] rw;
        int          len;
        logic [31:0] el24;
        logic [31:0] er24;
        logic [31:0] el16;
        logic [31:0] er16;
        bit          lat;
    } vec_t;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    logic CLOCK_50;
    logic resetn;
    logic bclk, lr, dat;

    i2s_adc_receiver_if #(.OUT_WIDTH(32)) bus24 ();
    i2s_adc_receiver_if #(.OUT_WIDTH(32)) bus16 ();

    assign bus24.AUD_BCLK    = bclk;
    assign bus24.AUD_ADCLRCK = lr;
    assign bus24.AUD_ADCDAT  = dat;
    assign bus16.AUD_BCLK    = bclk;
    assign bus16.AUD_ADCLRCK = lr;
    assign bus16.AUD_ADCDAT  = dat;

    i2s_adc_receiver #(.SAMPLE_BITS(24), .OUT_WIDTH(32)) dut24 (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus24)
    );

    i2s_adc_receiver #(.SAMPLE_BITS(16), .OUT_WIDTH(32)) dut16 (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus16)
    );

    int assertions = 0;
    int failures   = 0;

    pair_t q24[$];
    pair_t q16[$];
    logic  left_ok[2];
    logic  partial[2];
    int    exp_err[2];
    int    exp_valid[2];
    int    err_seen[2];
    int    valid_seen[2];
    logic  prev_v[2];
    logic  prev_e[2];
    logic  prev_lr_model;
    logic  check_latency = 1'b0;
    int    age = 0;
    logic  bclk_last = 1'b0;

    vec_t tbl[7];

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts CLOCK_50 edges since the latest BCLK pin rise (1 = first edge after it)
    initial begin
        forever begin
            @(posedge CLOCK_50);
            if (bclk && !bclk_last) age = 1;
            else age = age + 1;
            bclk_last = bclk;
        end
    end

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_output(input int w, input logic v, input logic [31:0] l,
                                input logic [31:0] r, input logic e);
        pair_t p;
        if (v) begin
            expect_eq($sformatf("valid_one_cycle[%0d]", w), {31'd0, prev_v[w]}, 32'd0);
            if ((w == 0 && q24.size() == 0) || (w == 1 && q16.size() == 0)) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected_valid[%0d]: got out_valid=1 expected no publish", w);
            end else begin
                p = (w == 0) ? q24.pop_front() : q16.pop_front();
                expect_eq($sformatf("out_L[%0d]", w), l, p.l);
                expect_eq($sformatf("out_R[%0d]", w), r, p.r);
            end
            valid_seen[w]++;
            if (w == 0 && check_latency) begin
                expect_eq("valid_latency", age, 32'd4);
                check_latency = 1'b0;
            end
        end
        if (e) begin
            if (prev_e[w]) expect_eq($sformatf("err_one_cycle[%0d]", w), 32'd1, 32'd0);
            else err_seen[w]++;
        end
        prev_v[w] = v;
        prev_e[w] = e;
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            prev_v[w] = 1'b0;
            prev_e[w] = 1'b0;
        end
        forever begin
            @(posedge CLOCK_50);
            #1;
            check_output(0, bus24.out_valid, bus24.out_L, bus24.out_R, bus24.frame_err);
            check_output(1, bus16.out_valid, bus16.out_L, bus16.out_R, bus16.frame_err);
        end
    end

    // Frame-level receiver model: decides whether a slot errors, stores a
    // left word, or publishes a pair; the published values come from the vector
    task automatic model_slot(input logic c, input int nbits, input logic edge_seen, input vec_t v);
        int n;
        for (int w = 0; w < 2; w++) begin
            n = (w == 0) ? 24 : 16;
            if (edge_seen) begin
                if (partial[w]) begin
                    exp_err[w]++;
                    left_ok[w] = 1'b0;
                end
                partial[w] = 1'b0;
                if (nbits < n) begin
                    partial[w] = 1'b1;
                end else if (!c) begin
                    left_ok[w] = 1'b1;
                end else begin
                    if (left_ok[w]) begin
                        exp_valid[w]++;
                        if (w == 0) q24.push_back('{l: v.el24, r: v.er24});
                        else q16.push_back('{l: v.el16, r: v.er16});
                    end
                    left_ok[w] = 1'b0;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            left_ok[w] = 1'b0;
            partial[w] = 1'b0;
        end
        prev_lr_model = 1'b0;
    endtask

    // One BCLK period (16 CLOCK_50 cycles): LRCK/data change on the falling edge
    task automatic drive_period(input logic c, input logic d);
        @(negedge CLOCK_50);
        bclk = 1'b0;
        lr   = c;
        dat  = d;
        repeat (8) @(negedge CLOCK_50);
        bclk = 1'b1;
        repeat (7) @(negedge CLOCK_50);
    endtask

    // Slot of len periods: one delay bit, then bits MSB first
    task automatic send_slot(input logic c, input logic [31:0] bits, input int len,
                             input vec_t v, input bit lat);
        logic edge_seen;
        edge_seen = (c !== prev_lr_model);
        model_slot(c, len - 1, edge_seen, v);
        prev_lr_model = c;
        if (lat) check_latency = 1'b1;
        for (int i = 0; i < len; i++) begin
            drive_period(c, (i == 0) ? 1'b0 : bits[32 - i]);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        send_slot(1'b0, v.lw, v.len, v, 1'b0);
        send_slot(1'b1, v.rw, v.len, v, v.lat);
    endtask

    task automatic check_counts(input string tag);
        expect_eq({tag, "_pending24"}, 32'(q24.size()), 32'd0);
        expect_eq({tag, "_pending16"}, 32'(q16.size()), 32'd0);
        for (int w = 0; w < 2; w++) begin
            expect_eq($sformatf("%s_valid_count[%0d]", tag, w), valid_seen[w], exp_valid[w]);
            expect_eq($sformatf("%s_err_count[%0d]", tag, w), err_seen[w], exp_err[w]);
        end
    endtask

    task automatic check_zero(input string tag);
        expect_eq({tag, "_L24"}, bus24.out_L, 32'd0);
        expect_eq({tag, "_R24"}, bus24.out_R, 32'd0);
        expect_eq({tag, "_valid24"}, {31'd0, bus24.out_valid}, 32'd0);
        expect_eq({tag, "_err24"}, {31'd0, bus24.frame_err}, 32'd0);
        expect_eq({tag, "_L16"}, bus16.out_L, 32'd0);
        expect_eq({tag, "_R16"}, bus16.out_R, 32'd0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{lw: 32'h7FFFFF00, rw: 32'h80000000, len: 25, el24: 32'h007FFFFF,
                   er24: 32'hFF800000, el16: 32'h00007FFF, er16: 32'hFFFF8000, lat: 1'b0};
        tbl[1] = tbl[0];
        tbl[2] = tbl[0];
        tbl[3] = '{lw: 32'h00000100, rw: 32'hFFFFFF00, len: 25, el24: 32'h00000001,
                   er24: 32'hFFFFFFFF, el16: 32'h00000000, er16: 32'hFFFFFFFF, lat: 1'b1};
        tbl[4] = '{lw: 32'h123456FF, rw: 32'hABCDEFFF, len: 33, el24: 32'h00123456,
                   er24: 32'hFFABCDEF, el16: 32'h00001234, er16: 32'hFFFFABCD, lat: 1'b0};
        tbl[5] = '{lw: 32'h800001FF, rw: 32'h7FFFFEFF, len: 33, el24: 32'hFF800001,
                   er24: 32'h007FFFFE, el16: 32'hFFFF8000, er16: 32'h00007FFF, lat: 1'b0};
        tbl[6] = '{lw: 32'h80000000, rw: 32'h7FFF0000, len: 33, el24: 32'hFF800000,
                   er24: 32'h007FFF00, el16: 32'hFFFF8000, er16: 32'h00007FFF, lat: 1'b0};

        for (int w = 0; w < 2; w++) begin
            exp_err[w]    = 0;
            exp_valid[w]  = 0;
            err_seen[w]   = 0;
            valid_seen[w] = 0;
        end
        model_reset();
        resetn = 1'b0;
        bclk   = 1'b0;
        lr     = 1'b0;
        dat    = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_zero("reset");
        resetn = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        $display("[TB] table frames");
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(tbl[i]);
            check_counts($sformatf("vec%0d", i));
            if (tbl[i].lat) expect_eq("latency_checked", {31'd0, check_latency}, 32'd0);
        end

        $display("[TB] truncated left slot");
        v = '{lw: 32'h00ABCD00, rw: 32'hF0000100, len: 25, el24: 32'h0000ABCD,
              er24: 32'hFFF00001, el16: 32'h000000AB, er16: 32'hFFFFF000, lat: 1'b0};
        send_slot(1'b0, 32'h55555555, 11, v, 1'b0);
        send_slot(1'b1, 32'h12345600, 25, v, 1'b0);
        apply_stimulus(v);
        check_counts("trunc");

        $display("[TB] reset mid right word");
        v = '{lw: 32'h65432100, rw: 32'h89ABCD00, len: 25, el24: 32'h00654321,
              er24: 32'hFF89ABCD, el16: 32'h00006543, er16: 32'hFFFF89AB, lat: 1'b0};
        send_slot(1'b0, 32'h11111100, 25, v, 1'b0);
        send_slot(1'b1, 32'h22222200, 13, v, 1'b0);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        model_reset();
        repeat (8) @(negedge CLOCK_50);
        // Pins stayed high through reset, so the receiver sees a word-clock edge
        // with a coincident bit-clock rise: the tail below is a short right word
        model_slot(1'b1, 12, 1'b1, v);
        prev_lr_model = 1'b1;
        for (int i = 0; i < 12; i++) drive_period(1'b1, i[0]);
        apply_stimulus(v);
        check_counts("reset");

        repeat (20) @(negedge CLOCK_50);
        check_counts("final");
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
